// File: rtl/bist_response_analyzer_if.sv
// Handshake and result bus between the BIST session driver and the response analyzer.
interface bist_response_analyzer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] golden_sig;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic [WIDTH-1:0] ref_data;
    logic             next_pattern;
    logic             busy;
    logic             done;
    logic             pass;
    logic             sig_match;
    logic [WIDTH-1:0] sig_out;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_fail_idx;

    // Session driver side
    modport master (
        output start, golden_sig, resp_valid, resp_data, ref_data,
        input  next_pattern, busy, done, pass, sig_match, sig_out,
               mismatch_cnt, first_fail_idx
    );

    // Analyzer side
    modport slave (
        input  start, golden_sig, resp_valid, resp_data, ref_data,
        output next_pattern, busy, done, pass, sig_match, sig_out,
               mismatch_cnt, first_fail_idx
    );
endinterface

// File: rtl/bist_response_analyzer.sv
// Output-response analyzer and session controller for the ALU BIST loop:
// compares each ALU response with the reference, compacts responses into a
// MISR signature and reports pass/fail against a golden signature.
module bist_response_analyzer #(
    parameter int unsigned       WIDTH         = 8,
    parameter int unsigned       PATTERN_COUNT = 255,
    parameter int unsigned       CNT_W         = 8,
    parameter logic [WIDTH-1:0]  MISR_POLY     = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0]  MISR_SEED     = WIDTH'(8'h00)
) (
    input  logic                     clk,
    input  logic                     rst,
    bist_response_analyzer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PATTERN_COUNT - 1);
    localparam logic [CNT_W-1:0] NO_FAIL   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mm_q, mm_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;
    logic             sig_match_q, sig_match_d;
    logic             pass_q, pass_d;
    logic             np_q, np_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer_c;
    logic             miscompare_c;
    logic [WIDTH-1:0] misr_next_c;

    // A response is consumed only while the analyzer is requesting patterns
    assign xfer_c       = np_q && bus.resp_valid;
    assign miscompare_c = (bus.resp_data != bus.ref_data);

    // Next MISR value: shift, fold the feedback polynomial, inject the response
    always_comb begin
        misr_next_c = {sig_q[WIDTH-2:0], 1'b0} ^ bus.resp_data;
        if (sig_q[WIDTH-1]) begin
            misr_next_c = misr_next_c ^ MISR_POLY;
        end
    end

    // Session FSM next-state, datapath updates and registered-output decode
    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        golden_d    = golden_q;
        cnt_d       = cnt_q;
        mm_d        = mm_q;
        ffi_d       = ffi_q;
        sig_match_d = sig_match_q;
        pass_d      = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    sig_d       = MISR_SEED;
                    golden_d    = bus.golden_sig;
                    cnt_d       = '0;
                    mm_d        = '0;
                    ffi_d       = NO_FAIL;
                    sig_match_d = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            S_RUN: begin
                if (xfer_c) begin
                    sig_d = misr_next_c;
                    cnt_d = cnt_q + CNT_ONE;
                    if (miscompare_c) begin
                        if (mm_q != NO_FAIL) begin
                            mm_d = mm_q + CNT_ONE;
                        end
                        if (ffi_q == NO_FAIL) begin
                            ffi_d = cnt_q;
                        end
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                sig_match_d = (sig_q == golden_q);
                pass_d      = (sig_q == golden_q) && (mm_q == '0);
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        np_d   = (state_d == S_RUN);
        busy_d = (state_d == S_RUN) || (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sig_q       <= MISR_SEED;
            golden_q    <= '0;
            cnt_q       <= '0;
            mm_q        <= '0;
            ffi_q       <= NO_FAIL;
            sig_match_q <= 1'b0;
            pass_q      <= 1'b0;
            np_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            golden_q    <= golden_d;
            cnt_q       <= cnt_d;
            mm_q        <= mm_d;
            ffi_q       <= ffi_d;
            sig_match_q <= sig_match_d;
            pass_q      <= pass_d;
            np_q        <= np_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.next_pattern   = np_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.sig_match      = sig_match_q;
    assign bus.sig_out        = sig_q;
    assign bus.mismatch_cnt   = mm_q;
    assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench for bist_response_analyzer: three instances with 2, 4 and
// 255 patterns per session, checked against a GF(2) polynomial signature model.
module tb_bist_response_analyzer;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0]         start_r;
    logic [NI-1:0]         valid_r;
    logic [W-1:0]          data_r;
    logic [W-1:0]          ref_r;
    logic [W-1:0]          golden_r;

    logic [NI-1:0]         np_w;
    logic [NI-1:0]         busy_w;
    logic [NI-1:0]         done_w;
    logic [NI-1:0]         pass_w;
    logic [NI-1:0]         sm_w;
    logic [NI-1:0][W-1:0]  sig_w;
    logic [NI-1:0][CW-1:0] mm_w;
    logic [NI-1:0][CW-1:0] ffi_w;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned PC = (g == 0) ? 2 : (g == 1) ? 4 : 255;
        bist_response_analyzer_if #(.WIDTH(W), .CNT_W(CW)) bus ();
        assign bus.start      = start_r[g];
        assign bus.golden_sig = golden_r;
        assign bus.resp_valid = valid_r[g];
        assign bus.resp_data  = data_r;
        assign bus.ref_data   = ref_r;
        assign np_w[g]   = bus.next_pattern;
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign pass_w[g] = bus.pass;
        assign sm_w[g]   = bus.sig_match;
        assign sig_w[g]  = bus.sig_out;
        assign mm_w[g]   = bus.mismatch_cnt;
        assign ffi_w[g]  = bus.first_fail_idx;
        bist_response_analyzer #(
            .WIDTH(W), .PATTERN_COUNT(PC), .CNT_W(CW),
            .MISR_POLY(8'h1D), .MISR_SEED(8'h00)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Stimulus arrays for the session being run
    logic [7:0] resp_a [256];
    logic [7:0] ref_a  [256];

    // GF(2)[x] product modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    // Signature after n responses from seed 0: sum of r_i * x^(n-1-i) mod p(x)
    function automatic logic [7:0] misr_of(int n);
        logic [7:0] s;
        logic [7:0] xp;
        s  = 8'h00;
        xp = 8'h01;
        for (int i = n - 1; i >= 0; i--) begin
            s  = s ^ gf_mul(resp_a[8'(i)], xp);
            xp = gf_mul(xp, 8'h02);
        end
        return s;
    endfunction

    typedef struct {
        int         k;
        logic [7:0] sig;
        bit         sm;
        bit         pass;
        logic [7:0] mm;
        logic [7:0] ffi;
    } res_t;

    res_t       resq [$];
    logic [7:0] sigq [$];

    // Monitor: per-transfer signature, signature hold, final results and done latency
    bit [NI-1:0]        pend;
    bit [NI-1:0]        pdone;
    logic [NI-1:0][7:0] cur_exp;
    int unsigned        lastx [NI];
    int unsigned        ncyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst) begin
                cur_exp[k] = 8'h00;
            end else if (pend[k]) begin
                if (sigq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sig_queue: transfer on instance %0d with no expected signature", k);
                end else begin
                    cur_exp[k] = sigq.pop_front();
                    check("sig_after_xfer", 32'(sig_w[k]), 32'(cur_exp[k]));
                end
            end else if (busy_w[k]) begin
                check("sig_hold", 32'(sig_w[k]), 32'(cur_exp[k]));
            end
            if (rst && done_w[k] && !pdone[k]) begin
                if (resq.size() == 0) begin
                    n_checks++;
                    $display("FAIL result_queue: done on instance %0d with no expected result", k);
                end else begin
                    res_t r;
                    r = resq.pop_front();
                    check("result_instance", 32'(k), 32'(r.k));
                    check("final_sig", 32'(sig_w[k]), 32'(r.sig));
                    check("sig_match", 32'(sm_w[k]), 32'(r.sm));
                    check("pass", 32'(pass_w[k]), 32'(r.pass));
                    check("mismatch_cnt", 32'(mm_w[k]), 32'(r.mm));
                    check("first_fail_idx", 32'(ffi_w[k]), 32'(r.ffi));
                    check("done_latency", ncyc - lastx[k], 2);
                end
            end
            if (rst && start_r[k] && !busy_w[k]) cur_exp[k] = 8'h00;
            pend[k] = rst && np_w[k] && valid_r[k];
            if (pend[k]) lastx[k] = ncyc;
            pdone[k] = rst && done_w[k];
        end
        ncyc++;
    end

    task automatic check_reset_state(input int k);
        check("rst_sig", 32'(sig_w[k]), 0);
        check("rst_done", 32'(done_w[k]), 0);
        check("rst_next_pattern", 32'(np_w[k]), 0);
        check("rst_busy", 32'(busy_w[k]), 0);
        check("rst_pass", 32'(pass_w[k]), 0);
        check("rst_sig_match", 32'(sm_w[k]), 0);
        check("rst_mismatch_cnt", 32'(mm_w[k]), 0);
        check("rst_first_fail_idx", 32'(ffi_w[k]), 32'hFF);
    endtask

    task automatic fill_random(input int n, input int err_pct);
        for (int i = 0; i < n; i++) begin
            resp_a[8'(i)] = 8'($urandom);
            ref_a[8'(i)]  = resp_a[8'(i)];
            if (int'($urandom_range(99)) < err_pct)
                ref_a[8'(i)] = resp_a[8'(i)] ^ 8'($urandom_range(1, 255));
        end
    endtask

    // stall_pct==200 selects the fixed valid pattern 1,0,0,1,...
    task automatic run_session(input int k, input int n, input logic [7:0] golden,
                               input int stall_pct, input bit poke, input int abort_at);
        res_t r;
        int   j;
        int   guard;
        int   phase;
        bit   v;
        r.k = k; r.sig = misr_of(n); r.mm = 8'h00; r.ffi = 8'hFF;
        for (int i = 0; i < n; i++) begin
            if (resp_a[8'(i)] != ref_a[8'(i)]) begin
                if (r.ffi == 8'hFF) r.ffi = 8'(i);
                r.mm = r.mm + 8'h01;
            end
        end
        r.sm   = (r.sig == golden);
        r.pass = r.sm && (r.mm == 8'h00);
        resq.push_back(r);

        golden_r   = golden;
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        golden_r   = 8'($urandom);
        check("next_pattern_after_start", 32'(np_w[k]), 1);

        j = 0; guard = 0; phase = 0;
        while (j < n && guard < 20000) begin
            if (abort_at > 0 && j == abort_at) break;
            data_r = resp_a[8'(j)];
            ref_r  = ref_a[8'(j)];
            if (stall_pct == 200) v = (phase % 4 == 0) || (phase % 4 == 3);
            else v = int'($urandom_range(99)) >= stall_pct;
            phase++;
            valid_r[k] = v;
            start_r[k] = poke && (j == n / 2);
            if (v && np_w[k]) begin
                sigq.push_back(misr_of(j + 1));
                j++;
            end
            @(posedge clk); #1;
            guard++;
        end
        start_r[k] = 1'b0;
        check("transfers_accepted", 32'(j), 32'((abort_at > 0) ? abort_at : n));

        if (abort_at > 0) begin
            valid_r[k] = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check_reset_state(k);
            void'(resq.pop_back());
            @(posedge clk); #1;
            rst = 1'b1;
            return;
        end

        // Extra responses after the last transfer must be ignored
        valid_r[k] = 1'b1;
        repeat (3) begin
            data_r = 8'($urandom);
            ref_r  = 8'($urandom);
            @(posedge clk); #1;
        end
        valid_r[k] = 1'b0;
        guard = 0;
        while (!done_w[k] && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_reached", 32'(done_w[k]), 1);
        repeat (2) @(posedge clk);
        #1;
        check("done_held", 32'(done_w[k]), 1);
        check("sig_held_after_done", 32'(sig_w[k]), 32'(r.sig));
    endtask

    initial begin
        logic [7:0] g;
        rst = 1'b0; start_r = '0; valid_r = '0;
        data_r = '0; ref_r = '0; golden_r = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) check_reset_state(k);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed MISR arithmetic: 80 then 00 gives 80, then 1D
        resp_a[0] = 8'h80; resp_a[1] = 8'h00;
        ref_a[0]  = 8'h80; ref_a[1]  = 8'h00;
        run_session(0, 2, 8'h1D, 0, 1'b0, 0);
        // Same data with valid pattern 1,0,0,1; start from DONE
        run_session(0, 2, 8'h1D, 200, 1'b0, 0);

        // Faults at patterns 1 and 3 with a matching golden
        fill_random(4, 0);
        ref_a[1] = resp_a[1] ^ 8'h5A;
        ref_a[3] = resp_a[3] ^ 8'h01;
        run_session(1, 4, misr_of(4), 0, 1'b0, 0);

        // All responses match, golden off by one bit
        fill_random(4, 0);
        run_session(1, 4, misr_of(4) ^ 8'h01, 20, 1'b0, 0);

        // start during RUN ignored, then identical rerun from DONE
        fill_random(4, 0);
        run_session(1, 4, misr_of(4), 0, 1'b1, 0);
        run_session(1, 4, misr_of(4), 30, 1'b0, 0);

        // Full 255-pattern sessions, clean and faulty
        fill_random(255, 0);
        run_session(2, 255, misr_of(255), 25, 1'b1, 0);
        fill_random(255, 5);
        run_session(2, 255, misr_of(255), 10, 1'b0, 0);

        // Reset in the middle of a run aborts it
        fill_random(255, 0);
        run_session(2, 255, misr_of(255), 10, 1'b0, 100);

        // Random sessions across all instances
        for (int s = 0; s < 8; s++) begin
            int k;
            int n;
            k = int'($urandom_range(NI - 1));
            n = (k == 0) ? 2 : (k == 1) ? 4 : 255;
            fill_random(n, int'($urandom_range(15)));
            g = misr_of(n);
            if ($urandom_range(1) == 1) g = g ^ 8'($urandom_range(1, 255));
            run_session(k, n, g, int'($urandom_range(50)), 1'($urandom_range(1)), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_sig_empty", 32'(sigq.size()), 0);
        check("scoreboard_result_empty", 32'(resq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
